// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: branch direction prediction and EX-stage branch resolution.
//   A 2-bit saturating-counter BHT supplies the IF prediction. EX-stage
//   conditional branches are resolved from the comparator flags and func3.
//   A mispredict raises a registered one-cycle redirect/flush and the EX
//   instruction of the following cycle is treated as wrong-path.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_pc               fetch PC used for the BHT lookup
//   if_pred_taken       combinational prediction (counter MSB)
//   ex_*                EX-stage instruction info and carried prediction
//   br_eq/br_lt/br_ltu  comparator flags for rs1/rs2
//   redirect/flush      registered one-cycle refetch pulse
//   redirect_pc         correct next PC, valid while redirect=1
// Optional: define BR_PERF_CNT_EN to add perf_br_cnt / perf_mispred_cnt.
module branch_pred_ctrl #(
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic [2:0]  ex_func3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
`ifdef BR_PERF_CNT_EN
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mispred_cnt,
`endif
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_RUN,
        ST_SHADOW
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_bht [DEPTH];
    logic              r_redirect;
    logic [31:0]       r_redirect_pc;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic              w_taken;
    logic              w_f3_ok;
    logic              w_resolve;
    logic              w_count;
    logic              w_mispred;
    logic [31:0]       w_correct_pc;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign if_pred_taken = r_bht[w_if_idx][1];

    // Branch outcome from func3 and comparator flags
    always_comb begin
        w_taken = 1'b0;
        w_f3_ok = 1'b1;
        case (ex_func3)
            3'b000:  w_taken = br_eq;
            3'b001:  w_taken = !br_eq;
            3'b100:  w_taken = br_lt;
            3'b101:  w_taken = !br_lt;
            3'b110:  w_taken = br_ltu;
            3'b111:  w_taken = !br_ltu;
            default: w_f3_ok = 1'b0;
        endcase
    end

    // Resolves are ignored in SHADOW: the EX instruction there is wrong-path
    assign w_resolve    = (r_state == ST_RUN) && ex_valid && !ex_stall && ex_is_branch;
    assign w_count      = w_resolve && w_f3_ok;
    assign w_mispred    = w_count && (w_taken != ex_pred_taken);
    assign w_correct_pc = w_taken ? ex_target : (ex_pc + 32'd4);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; SHADOW always lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_mispred) w_state_nxt = ST_SHADOW;
            ST_SHADOW: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Registered redirect pulse and target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_redirect <= w_mispred;
            if (w_mispred) r_redirect_pc <= w_correct_pc;
        end
    end

    assign redirect    = r_redirect;
    assign flush       = r_redirect;
    assign redirect_pc = r_redirect_pc;

    // BHT: saturating 2-bit counters, written on the resolving edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_bht[IDX_W'(i)] <= CTR_INIT;
        end else if (w_count) begin
            if (w_taken && (r_bht[w_ex_idx] != 2'b11))
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
            else if (!w_taken && (r_bht[w_ex_idx] != 2'b00))
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    // Performance counters, wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_count)   r_br_cnt      <= r_br_cnt + 32'd1;
            if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign perf_br_cnt      = r_br_cnt;
    assign perf_mispred_cnt = r_mispred_cnt;
`endif

endmodule
